fft_in_loader: RTL
==================

Name: fft_in_loader

Overview:
- Input stage of the 8-point floating-point FFT.
- Accepts a valid/ready stream of complex IEEE-754 single-precision samples and writes each frame of 8 into the 8x32 register bank through its load port.
- Addresses are bit-reversed (decimation-in-time ordering).
- After the 8th write it hands the frame to the butterfly controller with a start pulse, then stalls the stream until the controller reports done.

Parameters:
- BITREV, 1, 1 = write sample k to address bitrev3(k); 0 = write to address k.
- FRAME_CNT_W, 16, width of the frame counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- s_valid  in  1  input sample valid
- s_ready  out  1  loader can accept a sample
- s_re  in  32  sample real part (fp32)
- s_im  in  32  sample imaginary part (fp32)
- s_last  in  1  marks the 8th sample of a frame
- load_en  out  1  bank write enable
- load_addr  out  3  bank write address
- load_re  out  32  bank write data, real
- load_im  out  32  bank write data, imaginary
- core_start  out  1  one-cycle pulse: frame resident, start FFT
- core_done  in  1  controller finished the frame and the bank is free
- clr_err  in  1  clears err_frame
- err_frame  out  1  sticky framing error
- busy  out  1  high from the first accepted sample until core_done
- frame_cnt  out  FRAME_CNT_W  number of core_start pulses issued, wraps

Behaviour:
- Reset (async, rst_n=0):
  - state=FILL, sample count=0.
  - load_en=0, load_addr=0, load_re=0, load_im=0.
  - core_start=0, err_frame=0, busy=0, frame_cnt=0.
  - s_ready=1 in the first cycle after release.
- FSM states: FILL, START, WAIT.
- FILL:
  - s_ready=1.
  - A beat is accepted when s_valid && s_ready.
  - For accepted beat k (k=0..7), in the following cycle: load_en=1, load_addr=BITREV?{k[0],k[1],k[2]}:k, load_re/load_im = the captured s_re/s_im. Latency is one cycle; outputs are registered.
  - load_en=0 in any cycle that does not follow an acceptance. load_addr and data hold their last value.
  - The count increments per accepted beat.
  - On accepting k=7: count wraps to 0, state goes to START, and s_ready drops in the next cycle.
- START:
  - Entered in the cycle where the k=7 write is presented (load_en=1).
  - Lasts one cycle, then goes to WAIT with core_start=1 during that first WAIT cycle. core_start is therefore strictly after the last bank write.
  - frame_cnt increments in the same cycle core_start is high.
  - s_ready=0.
- WAIT:
  - s_ready=0, load_en=0.
  - core_done=1 → FILL next cycle; s_ready=1 in that cycle.
  - core_done while in FILL or START is ignored.
- busy:
  - Set in the cycle after the first beat (k=0) is accepted.
  - Cleared in the cycle after core_done is sampled in WAIT.
- Framing rules (s_last is used for checking only; it never changes addressing):
  - s_last=1 on k≠7 → err_frame set.
  - s_last=0 on k=7 → err_frame set.
  - The frame still completes on the 8-count in both cases.
- err_frame:
  - Sticky until clr_err.
  - clr_err in the same cycle as a new error: the error wins (err_frame stays 1).
- frame_cnt wraps from all-ones to 0.
- s_valid with s_ready=0: no acceptance, no side effects; the upstream source must hold the data.
- Reset mid-frame discards the partial frame. The bank contents are not touched by this block.

Decomposition:
- Shared package fft_pkg:
  - FFT_N=8, FFT_LOG2N=3
  - typedef cplx_t (struct: re, im as logic [31:0])
  - function bitrev3
  - enum loader_state_t {FILL, START, WAIT}
- No sub-module is needed. The single FSM plus counter and output registers is the natural size.

Test Plan:
- Reset then 8 back-to-back beats (s_valid held, re=k, im=0x3F800000, s_last on k=7) → load_addr sequence 0,4,2,6,1,5,3,7 on consecutive cycles, each one cycle after its acceptance; core_start=1 for exactly one cycle, one cycle after the addr=7 write; frame_cnt=1; s_ready=0 until core_done.
- BITREV=0 with the same stimulus → load_addr 0..7 in order; all other timing identical.
- s_valid toggled 1,0,1,0 during the frame → load_en pulses only after accepted beats, count still reaches 8, no extra writes.
- s_last asserted on k=3 → err_frame=1 from the next cycle; frame still finishes at k=7 with core_start; clr_err pulse → err_frame=0.
- core_done pulsed during START, then at WAIT+5 → first pulse ignored; s_ready rises exactly one cycle after the second pulse; a second frame gives frame_cnt=2.
- rst_n asserted asynchronously after 5 accepted beats → all outputs zero immediately; after release, the next 8 beats produce a full frame starting at address 0.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared types and helpers for the 8-point floating-point FFT.
// Used by the input loader and the butterfly controller.
package fft_pkg;

    localparam int FFT_N     = 8;
    localparam int FFT_LOG2N = 3;

    typedef struct packed {
        logic [31:0] re;
        logic [31:0] im;
    } cplx_t;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } loader_state_t;

    function automatic logic [FFT_LOG2N-1:0] bitrev3(
        input logic [FFT_LOG2N-1:0] k
    );
        return {k[0], k[1], k[2]};
    endfunction

endpackage

// File: rtl/fft_in_loader.sv
// FFT input stage: streams 8 complex samples into the register bank
// in bit-reversed order, then hands the frame to the core.
module fft_in_loader
    import fft_pkg::*;
#(
    parameter int BITREV      = 1,
    parameter int FRAME_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [31:0]            s_re,
    input  logic [31:0]            s_im,
    input  logic                   s_last,
    output logic                   load_en,
    output logic [2:0]             load_addr,
    output logic [31:0]            load_re,
    output logic [31:0]            load_im,
    output logic                   core_start,
    input  logic                   core_done,
    input  logic                   clr_err,
    output logic                   err_frame,
    output logic                   busy,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    loader_state_t          state;
    logic [FFT_LOG2N-1:0]   cnt;
    logic                   accept;
    logic                   last_beat;
    logic                   frame_err;
    logic [FFT_LOG2N-1:0]   wr_addr;
    cplx_t                  smp;

    assign s_ready   = (state == FILL);
    assign accept    = s_valid && s_ready;
    assign last_beat = (cnt == FFT_LOG2N'(FFT_N - 1));
    // s_last only flags misframing; the 8-count alone closes a frame
    assign frame_err = (s_last != last_beat);
    assign wr_addr   = (BITREV != 0) ? bitrev3(cnt) : cnt;
    assign smp       = '{re: s_re, im: s_im};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FILL;
            cnt        <= '0;
            load_en    <= 1'b0;
            load_addr  <= '0;
            load_re    <= '0;
            load_im    <= '0;
            core_start <= 1'b0;
            err_frame  <= 1'b0;
            busy       <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            load_en    <= accept;
            core_start <= 1'b0;

            if (accept) begin
                load_addr <= wr_addr;
                load_re   <= smp.re;
                load_im   <= smp.im;
                cnt       <= cnt + 1'b1;
                if (cnt == '0)
                    busy <= 1'b1;
            end

            // a fresh error beats a simultaneous clear
            if (accept && frame_err)
                err_frame <= 1'b1;
            else if (clr_err)
                err_frame <= 1'b0;

            unique case (state)
                FILL: begin
                    if (accept && last_beat)
                        state <= START;
                end
                START: begin
                    state      <= WAIT;
                    core_start <= 1'b1;
                    frame_cnt  <= frame_cnt + 1'b1;
                end
                WAIT: begin
                    if (core_done) begin
                        state <= FILL;
                        busy  <= 1'b0;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule
